// File: rtl/jtkcpu_mdu.sv
// jtkcpu_mdu: iterative multiply/divide unit sitting beside the CPU ALU.
// Define JTKCPU_MDU_EARLY_EN to end multiplies once no multiplier ones remain.
module jtkcpu_mdu #(
    parameter int AW = 16,
    parameter int BW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             start,
    input  logic             mode,
    input  logic             sign,
    input  logic             len,
    input  logic [AW-1:0]    op0,
    input  logic [BW-1:0]    op1,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    quot,
    output logic [BW-1:0]    rem,
    output logic [AW+BW-1:0] prod,
    output logic             v,
    output logic             dz
);
    localparam int HW = AW / 2;
    localparam int CW = $clog2(AW + 1);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] ULIM = (ONE << BW) - ONE;
    localparam logic [AW:0] SPOS = (ONE << (BW - 1)) - ONE;
    localparam logic [AW:0] SNEG = ONE << (BW - 1);

    typedef enum logic [1:0] { IDLE, PREP, RUN, FIX } state_t;
    state_t st, st_nx;

    logic             mode_r, sign_r;
    logic [AW-1:0]    a_r, a_mag, op0_ext, qr, qr_nx, q_sgn;
    logic [BW-1:0]    b_r, b_mag, mp, rr, rr_nx, r_sgn;
    logic [AW+BW-1:0] mc, acc, acc_nx, p_sgn;
    logic [BW:0]      trial;
    logic [CW-1:0]    cnt;
    logic             a_neg, b_neg, q_neg, ge, q_ovf, div0;

    // short dividends come from the low half, extended per the sign mode
    assign op0_ext = len ? op0 :
                     {{(AW-HW){sign & op0[HW-1]}}, op0[HW-1:0]};

    assign a_neg = sign_r & a_r[AW-1];
    assign b_neg = sign_r & b_r[BW-1];
    assign q_neg = a_neg ^ b_neg;
    assign a_mag = a_neg ? -a_r : a_r;
    assign b_mag = b_neg ? -b_r : b_r;
    assign div0  = ~mode_r & (b_r == '0);
    assign busy  = (st != IDLE);

    // restoring divide step; the partial remainder never exceeds BW bits
    assign trial = {rr, qr[AW-1]};
    assign ge    = (trial >= {1'b0, mp});
    assign rr_nx = ge ? BW'(trial - {1'b0, mp}) : trial[BW-1:0];
    assign qr_nx = {qr[AW-2:0], ge};

    assign acc_nx = mp[0] ? acc + mc : acc;

    assign q_sgn = q_neg ? -qr : qr;
    assign r_sgn = a_neg ? -rr : rr;
    assign p_sgn = q_neg ? -acc : acc;

    always_comb begin
        q_ovf = 1'b0;
        if (!sign_r)
            q_ovf = ({1'b0, qr} > ULIM);
        else if (q_neg)
            q_ovf = ({1'b0, qr} > SNEG);
        else
            q_ovf = ({1'b0, qr} > SPOS);
    end

    always_ff @(posedge clk) begin
        if (rst)
            st <= IDLE;
        else
            st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        if (cen) begin
            unique case (st)
                IDLE: begin
                    if (start)
                        st_nx = PREP;
                end
                PREP: begin
                    st_nx = RUN;
                    if (div0)
                        st_nx = FIX;
`ifdef JTKCPU_MDU_EARLY_EN
                    if (mode_r && b_mag == '0)
                        st_nx = FIX;
`endif
                end
                RUN: begin
                    if (cnt == CW'(1))
                        st_nx = FIX;
`ifdef JTKCPU_MDU_EARLY_EN
                    if (mode_r && mp[BW-1:1] == '0)
                        st_nx = FIX;
`endif
                end
                FIX: st_nx = IDLE;
                default: st_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r <= 1'b0;
            sign_r <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            qr     <= '0;
            rr     <= '0;
            mp     <= '0;
            mc     <= '0;
            acc    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            quot   <= '0;
            rem    <= '0;
            prod   <= '0;
            v      <= 1'b0;
            dz     <= 1'b0;
        end else begin
            // done is a single clk pulse regardless of cen
            done <= 1'b0;
            if (cen) begin
                unique case (st)
                    IDLE: begin
                        if (start) begin
                            a_r    <= mode ? op0 : op0_ext;
                            b_r    <= op1;
                            mode_r <= mode;
                            sign_r <= sign;
                        end
                    end
                    PREP: begin
                        qr  <= a_mag;
                        rr  <= '0;
                        mp  <= b_mag;
                        mc  <= {{BW{1'b0}}, a_mag};
                        acc <= '0;
                        cnt <= mode_r ? CW'(BW) : CW'(AW);
                    end
                    RUN: begin
                        cnt <= cnt - CW'(1);
                        if (mode_r) begin
                            acc <= acc_nx;
                            mc  <= mc << 1;
                            mp  <= mp >> 1;
                        end else begin
                            qr <= qr_nx;
                            rr <= rr_nx;
                        end
                    end
                    FIX: begin
                        done <= 1'b1;
                        if (mode_r) begin
                            prod <= p_sgn;
                            v    <= 1'b0;
                            dz   <= 1'b0;
                        end else if (div0) begin
                            quot <= '1;
                            rem  <= a_r[BW-1:0];
                            v    <= 1'b1;
                            dz   <= 1'b1;
                        end else begin
                            quot <= q_sgn;
                            rem  <= r_sgn;
                            v    <= q_ovf;
                            dz   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtkcpu_mdu.sv
// tb_jtkcpu_mdu: directed checks of jtkcpu_mdu (AW=16, BW=8).
// Expected values are hand-computed per operation.
module tb_jtkcpu_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        sign = 1'b0;
    logic        len = 1'b1;
    logic [15:0] op0 = '0;
    logic [7:0]  op1 = '0;
    logic        busy, done, v, dz;
    logic [15:0] quot;
    logic [7:0]  rem;
    logic [23:0] prod;

    int checks = 0;
    int errors = 0;
    int lat, bcnt, n, k, lat3, lat0, lat1;
    bit stable, got;

    jtkcpu_mdu #(.AW(16), .BW(8)) dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start),
        .mode(mode), .sign(sign), .len(len),
        .op0(op0), .op1(op1),
        .busy(busy), .done(done), .quot(quot), .rem(rem),
        .prod(prod), .v(v), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic m, input logic s, input logic l,
                          input logic [15:0] a, input logic [7:0] b,
                          output int lt, output int bc, output bit stb);
        logic [15:0] q0;
        logic [7:0]  r0;
        logic [23:0] p0;
        mode = m; sign = s; len = l; op0 = a; op1 = b;
        start = 1'b1;
        edge_();
        start = 1'b0;
        q0 = quot; r0 = rem; p0 = prod;
        lt = 0;
        bc = busy ? 1 : 0;
        stb = 1'b1;
        while (!done && lt < 100) begin
            edge_();
            lt++;
            if (!done) begin
                if (busy) bc++;
                if (quot !== q0 || rem !== r0 || prod !== p0)
                    stb = 1'b0;
            end
        end
    endtask

    initial begin
`ifdef JTKCPU_MDU_EARLY_EN
        lat3 = 4; lat0 = 2; lat1 = 3;
`else
        lat3 = 10; lat0 = 10; lat1 = 10;
`endif
        edge_();
        edge_();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_prod", prod, 0);
        chk("rst_v", v, 0);
        chk("rst_dz", dz, 0);

        // 1: unsigned 1000/7
        run_op(0, 0, 1, 16'd1000, 8'd7, lat, bcnt, stable);
        chk("t1_lat", lat, 18);
        chk("t1_busy_cycles", bcnt, 18);
        chk("t1_busy_end", busy, 0);
        chk("t1_quot", quot, 142);
        chk("t1_rem", rem, 6);
        chk("t1_v", v, 0);
        chk("t1_dz", dz, 0);
        edge_();
        chk("t1_done_pulse", done, 0);

        // 2: signed -701/7
        run_op(0, 1, 1, 16'hFD43, 8'd7, lat, bcnt, stable);
        chk("t2_hold", stable, 1);
        chk("t2_quot", quot, 16'hFF9C);
        chk("t2_rem", rem, 8'hFF);
        chk("t2_v", v, 0);

        // 3: unsigned overflow, then short signed dividend
        run_op(0, 0, 1, 16'h1234, 8'd2, lat, bcnt, stable);
        chk("t3_quot", quot, 16'h091A);
        chk("t3_rem", rem, 0);
        chk("t3_v", v, 1);
        run_op(0, 1, 0, 16'hAB34, 8'd2, lat, bcnt, stable);
        chk("t3_len_quot", quot, 16'h001A);
        chk("t3_len_v", v, 0);

        // signed range edges and most-negative divisor
        run_op(0, 1, 1, 16'd1000, 8'd7, lat, bcnt, stable);
        chk("sv_quot", quot, 16'h008E);
        chk("sv_v", v, 1);
        run_op(0, 1, 1, 16'hFC80, 8'd7, lat, bcnt, stable);
        chk("sn_quot", quot, 16'hFF80);
        chk("sn_rem", rem, 0);
        chk("sn_v", v, 0);
        run_op(0, 1, 1, 16'h0100, 8'h80, lat, bcnt, stable);
        chk("s80_quot", quot, 16'hFFFE);
        chk("s80_v", v, 0);

        // 4: divide by zero
        run_op(0, 0, 1, 16'd1000, 8'd0, lat, bcnt, stable);
        chk("t4_lat", lat, 2);
        chk("t4_dz", dz, 1);
        chk("t4_v", v, 1);
        chk("t4_quot", quot, 16'hFFFF);
        chk("t4_rem", rem, 8'hE8);
        edge_();
        edge_();
        run_op(0, 0, 1, 16'd1000, 8'd7, lat, bcnt, stable);
        chk("t4_dz_clr", dz, 0);
        chk("t4_v_clr", v, 0);

        // 5: multiplies
        run_op(1, 1, 1, 16'h8000, 8'hFF, lat, bcnt, stable);
        chk("t5_sneg1", prod, 24'h008000);
        chk("t5_sneg1_lat", lat, lat1);
        run_op(1, 0, 0, 16'hFFFF, 8'hFF, lat, bcnt, stable);
        chk("t5_umax", prod, 24'hFEFF01);
        chk("t5_umax_lat", lat, 10);
        chk("t5_v", v, 0);
        chk("t5_dz", dz, 0);
        chk("t5_quot_kept", quot, 142);
        run_op(1, 1, 1, 16'h8000, 8'h80, lat, bcnt, stable);
        chk("t5_both_min", prod, 24'h400000);
        run_op(1, 0, 1, 16'h1234, 8'h03, lat, bcnt, stable);
        chk("t5_x3", prod, 24'h00369C);
        chk("t5_x3_lat", lat, lat3);
        run_op(1, 1, 1, 16'h1234, 8'h00, lat, bcnt, stable);
        chk("t5_x0", prod, 0);
        chk("t5_x0_lat", lat, lat0);

        // 6: cen 1-of-3, reset mid-run
        mode = 0; sign = 0; len = 1; op0 = 16'd1000; op1 = 8'd7;
        cen = 1'b1; start = 1'b1;
        edge_();
        start = 1'b0;
        n = 0; k = 0;
        while (n < 5 && k < 100) begin
            cen = (k % 3 == 2);
            k++;
            edge_();
            if (cen) n++;
        end
        chk("t6_busy_mid", busy, 1);
        rst = 1'b1; cen = 1'b1;
        edge_();
        rst = 1'b0;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_quot", quot, 0);
        chk("t6_rst_rem", rem, 0);
        chk("t6_rst_prod", prod, 0);

        // restart with an ignored start pulse while busy
        start = 1'b1;
        edge_();
        start = 1'b0;
        n = 0; k = 0; got = 1'b0;
        while (!got && k < 300) begin
            cen = (k % 3 == 2);
            k++;
            if (n == 3 && cen) begin
                start = 1'b1; mode = 1'b1;
                op0 = 16'hFFFF; op1 = 8'hFF;
            end
            edge_();
            start = 1'b0;
            if (cen) n++;
            got = done;
        end
        chk("t6_done_seen", got, 1);
        chk("t6_cen_edges", n, 18);
        chk("t6_quot", quot, 142);
        chk("t6_rem", rem, 6);
        chk("t6_prod_kept", prod, 0);
        cen = 1'b0;
        edge_();
        chk("t6_done_once", done, 0);
        start = 1'b1;
        edge_();
        start = 1'b0;
        chk("t6_nocen_start", busy, 0);
        cen = 1'b1;
        edge_();
        chk("t6_nocen_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
